// File: rtl/recovery_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared definitions for the recovery controller and its neighbours:
//   exception codes reported by the ROB head, the program-counter type, the
//   recovery FSM state encoding and the default widths of the ROB occupancy
//   and per-cycle rewind count buses.
// -----------------------------------------------------------------------------
package sys_defs;

    // Default configuration of the recovery path.
    localparam int DEF_WAY            = 3;
    localparam int DEF_ROB_SIZE       = 32;
    localparam int DEF_PC_W           = 32;
    localparam int DEF_REWIND_TIMEOUT = 64;

    // Occupancy counts 0..ROB_SIZE inclusive; rewind count 0..WAY inclusive.
    localparam int ROB_CNT_W    = $clog2(DEF_ROB_SIZE + 1);
    localparam int REWIND_NUM_W = $clog2(DEF_WAY + 1);

    typedef logic [DEF_PC_W-1:0] PC_t;

    // NO_ERROR at the ROB head means a branch mispredict, not a fault.
    typedef enum logic [3:0] {
        NO_ERROR            = 4'h0,
        INST_ADDR_MISALIGN  = 4'h1,
        INST_ACCESS_FAULT   = 4'h2,
        ILLEGAL_INST        = 4'h3,
        BREAKPOINT          = 4'h4,
        LOAD_ADDR_MISALIGN  = 4'h5,
        LOAD_ACCESS_FAULT   = 4'h6,
        STORE_ADDR_MISALIGN = 4'h7,
        STORE_ACCESS_FAULT  = 4'h8,
        HALTED_ON_WFI       = 4'hE
    } exception_code_e;

    typedef enum logic [2:0] {
        RS_IDLE   = 3'd0,
        RS_DRAIN  = 3'd1,
        RS_REWIND = 3'd2,
        RS_FLUSH  = 3'd3,
        RS_RESUME = 3'd4,
        RS_HALT   = 3'd5
    } recovery_state_e;

endpackage

// File: rtl/recovery_ctrl_stats.sv
// -----------------------------------------------------------------------------
// recovery_stats
//   Saturating 32-bit counter bank observing the recovery controller.
//   Ports:
//     clock, reset        clock and asynchronous active-low reset
//     inc_recovery        +1 to stat_recoveries (FLUSH entry)
//     inc_penalty         +1 to stat_penalty_cycles (busy, not halted)
//     rewound_add         amount added to stat_rewound this cycle
//     stat_*              counter values, all stick at all-ones
// -----------------------------------------------------------------------------
module recovery_stats #(
    parameter int ADD_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_recovery,
    input  logic             inc_penalty,
    input  logic [ADD_W-1:0] rewound_add,
    output logic [31:0]      stat_recoveries,
    output logic [31:0]      stat_penalty_cycles,
    output logic [31:0]      stat_rewound
);

    logic [31:0] recoveries_q, recoveries_d;
    logic [31:0] penalty_q,    penalty_d;
    logic [31:0] rewound_q,    rewound_d;
    logic [32:0] rewound_sum;

    always_comb begin
        recoveries_d = recoveries_q;
        penalty_d    = penalty_q;
        if (inc_recovery && (recoveries_q != '1)) recoveries_d = recoveries_q + 32'd1;
        if (inc_penalty  && (penalty_q    != '1)) penalty_d    = penalty_q + 32'd1;
        // One spare bit catches the carry so the sum clamps instead of wrapping.
        rewound_sum = {1'b0, rewound_q} + 33'(rewound_add);
        rewound_d   = rewound_sum[32] ? '1 : rewound_sum[31:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            recoveries_q <= '0;
            penalty_q    <= '0;
            rewound_q    <= '0;
        end else begin
            recoveries_q <= recoveries_d;
            penalty_q    <= penalty_d;
            rewound_q    <= rewound_d;
        end
    end

    assign stat_recoveries     = recoveries_q;
    assign stat_penalty_cycles = penalty_q;
    assign stat_rewound        = rewound_q;

endmodule

// File: rtl/recovery_ctrl.sv
// -----------------------------------------------------------------------------
// recovery_ctrl
//   Sequences branch-mispredict recovery around the reorder buffer: stall
//   dispatch, wait for retired stores to drain, let the ROB roll back younger
//   entries (up to WAY per cycle), then pulse a one-cycle fetch/store flush
//   with the redirect PC, and settle for one RESUME cycle. Any head exception
//   other than NO_ERROR (WFI, illegal instruction, ...) parks the core in a
//   sticky HALT until reset.
//
//   Ports:
//     clock, reset      clock, asynchronous active-low reset
//     exc_valid         ROB head complete and flagged
//     exc_code          exception code of the head (NO_ERROR = mispredict)
//     exc_target_pc     resolved target PC
//     rob_occupancy     valid ROB entries including the head
//     rewind_num        entries the ROB rolled back this cycle
//     sq_drained        no retired-but-unwritten stores remain
//     rewind_go         ROB may roll back this cycle        (combinational)
//     dispatch_stall    block dispatch                      (combinational)
//     fetch_flush       one-cycle flush pulse               (registered)
//     store_flush       one-cycle speculative store squash  (registered)
//     redirect_pc       new fetch PC while fetch_flush=1    (registered)
//     halt, halt_code   sticky halt and its cause           (registered)
//     busy              FSM not idle                        (registered)
//     err_timeout       sticky: DRAIN+REWIND ran too long   (registered)
//     err_protocol      sticky: ROB over-rewound / empty    (registered)
//
//   Build option RECOVERY_STATS_EN adds stat_recoveries, stat_penalty_cycles
//   and stat_rewound saturating counters via recovery_stats.
// -----------------------------------------------------------------------------
module recovery_ctrl
    import sys_defs::*;
#(
    parameter int WAY            = DEF_WAY,
    parameter int ROB_SIZE       = DEF_ROB_SIZE,
    parameter int PC_W           = DEF_PC_W,
    parameter int REWIND_TIMEOUT = DEF_REWIND_TIMEOUT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exc_valid,
    input  logic [3:0]                    exc_code,
    input  logic [PC_W-1:0]               exc_target_pc,
    input  logic [$clog2(ROB_SIZE+1)-1:0] rob_occupancy,
    input  logic [$clog2(WAY+1)-1:0]      rewind_num,
    input  logic                          sq_drained,
    output logic                          rewind_go,
    output logic                          dispatch_stall,
    output logic                          fetch_flush,
    output logic                          store_flush,
    output logic [PC_W-1:0]               redirect_pc,
    output logic                          halt,
    output logic [3:0]                    halt_code,
    output logic                          busy,
    output logic                          err_timeout,
    output logic                          err_protocol
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0]                   stat_recoveries,
    output logic [31:0]                   stat_penalty_cycles,
    output logic [31:0]                   stat_rewound
`endif
);

    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam int TMO_W = $clog2(REWIND_TIMEOUT + 1);

    recovery_state_e state_q, state_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]       halt_code_q, halt_code_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_protocol_q, err_protocol_d;
    logic             fetch_flush_q, fetch_flush_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             halt_q, halt_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] rewind_ext;
    logic [TMO_W-1:0] tmo_cnt_inc;
    logic             tmo_hit;

    assign rewind_ext  = CNT_W'(rewind_num);
    assign tmo_cnt_inc = tmo_cnt_q + TMO_W'(1);
    // This cycle is the last one DRAIN+REWIND is allowed to occupy.
    assign tmo_hit     = (tmo_cnt_inc == TMO_W'(REWIND_TIMEOUT));

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        remaining_d    = remaining_q;
        tmo_cnt_d      = tmo_cnt_q;
        halt_code_d    = halt_code_q;
        err_timeout_d  = err_timeout_q;
        err_protocol_d = err_protocol_q;

        unique case (state_q)
            RS_IDLE: begin
                if (exc_valid) begin
                    if (exc_code != NO_ERROR) begin
                        state_d     = RS_HALT;
                        halt_code_d = exc_code;
                    end else begin
                        state_d   = RS_DRAIN;
                        tgt_d     = exc_target_pc;
                        tmo_cnt_d = '0;
                        // The head itself is not rewound, only younger entries.
                        if (rob_occupancy == '0) begin
                            remaining_d    = '0;
                            err_protocol_d = 1'b1;
                        end else begin
                            remaining_d = rob_occupancy - CNT_W'(1);
                        end
                    end
                end
            end
            RS_DRAIN: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (sq_drained) state_d = (remaining_q == '0) ? RS_FLUSH : RS_REWIND;
                if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = RS_FLUSH;
                end
            end
            RS_REWIND: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (rewind_ext > remaining_q) begin
                    remaining_d    = '0;
                    err_protocol_d = 1'b1;
                end else begin
                    remaining_d = remaining_q - rewind_ext;
                end
                if (remaining_d == '0) state_d = RS_FLUSH;
                if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = RS_FLUSH;
                end
            end
            RS_FLUSH:  state_d = RS_RESUME;
            RS_RESUME: state_d = RS_IDLE;
            RS_HALT:   state_d = RS_HALT;
            default:   state_d = RS_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered so they
        // line up with that state rather than lagging it by a cycle.
        fetch_flush_d = (state_d == RS_FLUSH);
        redirect_pc_d = (state_d == RS_FLUSH) ? tgt_d : '0;
        halt_d        = (state_d == RS_HALT);
        busy_d        = (state_d != RS_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= RS_IDLE;
            tgt_q          <= '0;
            remaining_q    <= '0;
            tmo_cnt_q      <= '0;
            halt_code_q    <= NO_ERROR;
            err_timeout_q  <= 1'b0;
            err_protocol_q <= 1'b0;
            fetch_flush_q  <= 1'b0;
            redirect_pc_q  <= '0;
            halt_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            remaining_q    <= remaining_d;
            tmo_cnt_q      <= tmo_cnt_d;
            halt_code_q    <= halt_code_d;
            err_timeout_q  <= err_timeout_d;
            err_protocol_q <= err_protocol_d;
            fetch_flush_q  <= fetch_flush_d;
            redirect_pc_q  <= redirect_pc_d;
            halt_q         <= halt_d;
            busy_q         <= busy_d;
        end
    end

    // Every non-idle state holds dispatch off, including HALT.
    assign rewind_go      = (state_q == RS_REWIND);
    assign dispatch_stall = (state_q != RS_IDLE);

    assign fetch_flush  = fetch_flush_q;
    assign store_flush  = fetch_flush_q;
    assign redirect_pc  = redirect_pc_q;
    assign halt         = halt_q;
    assign halt_code    = halt_code_q;
    assign busy         = busy_q;
    assign err_timeout  = err_timeout_q;
    assign err_protocol = err_protocol_q;

`ifdef RECOVERY_STATS_EN
    logic [CNT_W-1:0] rewound_amt;
    // Count what the ROB could legally have removed, not what it claimed.
    assign rewound_amt = (state_q != RS_REWIND)      ? '0 :
                         (rewind_ext > remaining_q)  ? remaining_q : rewind_ext;

    recovery_stats #(
        .ADD_W (CNT_W)
    ) u_stats (
        .clock               (clock),
        .reset               (reset),
        .inc_recovery        ((state_d == RS_FLUSH) && (state_q != RS_FLUSH)),
        .inc_penalty         ((state_q != RS_IDLE) && (state_q != RS_HALT)),
        .rewound_add         (rewound_amt),
        .stat_recoveries     (stat_recoveries),
        .stat_penalty_cycles (stat_penalty_cycles),
        .stat_rewound        (stat_rewound)
    );
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_recovery_ctrl
//   Directed bench for recovery_ctrl. Stimulus pushes each expected flush or
//   halt event (PC, code, cycle, error flags) into a queue; a monitor on the
//   falling edge pops and compares whenever the DUT pulses fetch_flush or
//   raises halt. Per-cycle phase checks cover rewind_go/dispatch_stall/busy.
//   The DUT runs with REWIND_TIMEOUT=8.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_recovery_ctrl;
    import sys_defs::*;

    localparam int PC_W = 32;
    localparam int TMO  = 8;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    exc_valid;
    logic [3:0]              exc_code;
    logic [PC_W-1:0]         exc_target_pc;
    logic [ROB_CNT_W-1:0]    rob_occupancy;
    logic [REWIND_NUM_W-1:0] rewind_num;
    logic                    sq_drained;
    logic                    rewind_go, dispatch_stall, fetch_flush, store_flush;
    logic [PC_W-1:0]         redirect_pc;
    logic                    halt, busy, err_timeout, err_protocol;
    logic [3:0]              halt_code;
`ifdef RECOVERY_STATS_EN
    logic [31:0]             stat_recoveries, stat_penalty_cycles, stat_rewound;
`endif

    recovery_ctrl #(
        .WAY            (DEF_WAY),
        .ROB_SIZE       (DEF_ROB_SIZE),
        .PC_W           (PC_W),
        .REWIND_TIMEOUT (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_target_pc  (exc_target_pc),
        .rob_occupancy  (rob_occupancy),
        .rewind_num     (rewind_num),
        .sq_drained     (sq_drained),
        .rewind_go      (rewind_go),
        .dispatch_stall (dispatch_stall),
        .fetch_flush    (fetch_flush),
        .store_flush    (store_flush),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halt_code      (halt_code),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_protocol   (err_protocol)
`ifdef RECOVERY_STATS_EN
        ,
        .stat_recoveries     (stat_recoveries),
        .stat_penalty_cycles (stat_penalty_cycles),
        .stat_rewound        (stat_rewound)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {EV_FLUSH = 0, EV_HALT = 1} ev_kind_e;
    typedef struct {
        ev_kind_e        kind;
        logic [PC_W-1:0] pc;
        logic [3:0]      code;
        int              cyc;
        logic            err_t;
        logic            err_p;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic halt_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (fetch_flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flush", 64'(redirect_pc), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("ev_kind_flush", 64'(int'(e.kind)), 64'(int'(EV_FLUSH)));
                check("redirect_pc",   64'(redirect_pc),  64'(e.pc));
                check("flush_cycle",   64'(cyc),          64'(e.cyc));
                check("store_flush",   64'(store_flush),  64'd1);
                check("flush_stall",   64'(dispatch_stall), 64'd1);
                check("flush_err_tmo", 64'(err_timeout),  64'(e.err_t));
                check("flush_err_pro", 64'(err_protocol), 64'(e.err_p));
            end
        end
        if (halt && !halt_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_halt", 64'(halt_code), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("ev_kind_halt", 64'(int'(e.kind)), 64'(int'(EV_HALT)));
                check("halt_code",    64'(halt_code),    64'(e.code));
                check("halt_cycle",   64'(cyc),          64'(e.cyc));
            end
        end
        halt_prev <= halt;
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic phase(input string name, input logic rg, input logic ds, input logic bz);
        check({name, "_rewind_go"}, 64'(rewind_go),      64'(rg));
        check({name, "_stall"},     64'(dispatch_stall), 64'(ds));
        check({name, "_busy"},      64'(busy),           64'(bz));
    endtask

    // Drive a mispredict now and queue the flush expected flush_off cycles later.
    task automatic issue_mispredict(input logic [PC_W-1:0] pc, input int occ,
                                    input int flush_off, input logic et, input logic ep);
        exc_valid     = 1'b1;
        exc_code      = NO_ERROR;
        exc_target_pc = pc;
        rob_occupancy = ROB_CNT_W'(occ);
        exp_q.push_back('{kind: EV_FLUSH, pc: pc, code: 4'(NO_ERROR),
                          cyc: cyc + flush_off, err_t: et, err_p: ep});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rewind_go"},   64'(rewind_go),      64'd0);
        check({name, "_stall"},       64'(dispatch_stall), 64'd0);
        check({name, "_fetch_flush"}, 64'(fetch_flush),    64'd0);
        check({name, "_store_flush"}, 64'(store_flush),    64'd0);
        check({name, "_redirect"},    64'(redirect_pc),    64'd0);
        check({name, "_halt"},        64'(halt),           64'd0);
        check({name, "_halt_code"},   64'(halt_code),      64'(NO_ERROR));
        check({name, "_busy"},        64'(busy),           64'd0);
        check({name, "_err_tmo"},     64'(err_timeout),    64'd0);
        check({name, "_err_pro"},     64'(err_protocol),   64'd0);
    endtask

    // --------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int held;
        exc_valid     = 1'b0;
        exc_code      = NO_ERROR;
        exc_target_pc = '0;
        rob_occupancy = '0;
        rewind_num    = '0;
        sq_drained    = 1'b1;

        // Reset state
        #2;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        phase("idle0", 1'b0, 1'b0, 1'b0);

        // T1: mispredict, occupancy 8 -> 7 younger, rewind 3,3,1
        issue_mispredict(32'h0000_1040, 8, 5, 1'b0, 1'b0);
        tick();                                    // DRAIN
        exc_valid = 1'b0;
        phase("t1_drain", 1'b0, 1'b1, 1'b1);
        tick(); rewind_num = 2'd3; phase("t1_rw0", 1'b1, 1'b1, 1'b1);
        tick(); rewind_num = 2'd3; phase("t1_rw1", 1'b1, 1'b1, 1'b1);
        tick(); rewind_num = 2'd1; phase("t1_rw2", 1'b1, 1'b1, 1'b1);
        tick(); rewind_num = 2'd0; phase("t1_flush", 1'b0, 1'b1, 1'b1);
        tick(); phase("t1_resume", 1'b0, 1'b1, 1'b1);
        tick(); phase("t1_idle", 1'b0, 1'b0, 1'b0);
        check("t1_err_tmo", 64'(err_timeout), 64'd0);
        check("t1_err_pro", 64'(err_protocol), 64'd0);

        // T2: store queue busy for 4 DRAIN cycles, occupancy 1 -> straight to FLUSH
        sq_drained = 1'b0;
        issue_mispredict(32'h0000_2200, 1, 6, 1'b0, 1'b0);
        tick();
        exc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            phase("t2_drain_wait", 1'b0, 1'b1, 1'b1);
            tick();
        end
        phase("t2_drain_last", 1'b0, 1'b1, 1'b1);
        sq_drained = 1'b1;
        tick(); phase("t2_flush", 1'b0, 1'b1, 1'b1);
        tick(); phase("t2_resume", 1'b0, 1'b1, 1'b1);
        tick(); phase("t2_idle", 1'b0, 1'b0, 1'b0);

        // T3: remaining 2, ROB claims 3 -> protocol error, clamp, FLUSH next cycle
        issue_mispredict(32'h0000_3300, 3, 3, 1'b0, 1'b1);
        tick();
        exc_valid = 1'b0;
        tick(); rewind_num = 2'd3; phase("t3_rw", 1'b1, 1'b1, 1'b1);
        check("t3_err_pro_before", 64'(err_protocol), 64'd0);
        tick(); rewind_num = 2'd0; phase("t3_flush", 1'b0, 1'b1, 1'b1);
        check("t3_err_pro_after", 64'(err_protocol), 64'd1);
        tick();
        tick(); phase("t3_idle", 1'b0, 1'b0, 1'b0);

        // T4: ROB never rewinds, occupancy 10 -> forced FLUSH after 8 cycles
        rewind_num = 2'd0;
        issue_mispredict(32'h0000_4400, 10, 9, 1'b1, 1'b1);
        tick();
        exc_valid = 1'b0;
        for (int i = 2; i <= TMO; i++) begin
            tick();
            phase("t4_rw", 1'b1, 1'b1, 1'b1);
        end
        check("t4_err_tmo_before", 64'(err_timeout), 64'd0);
        tick(); check("t4_err_tmo_after", 64'(err_timeout), 64'd1);
        tick();
        tick(); phase("t4_idle", 1'b0, 1'b0, 1'b0);

        // T5: WFI halts next cycle and holds through 100 cycles of further exceptions
        exc_valid     = 1'b1;
        exc_code      = HALTED_ON_WFI;
        rob_occupancy = ROB_CNT_W'(5);
        exp_q.push_back('{kind: EV_HALT, pc: '0, code: 4'(HALTED_ON_WFI),
                          cyc: cyc + 1, err_t: 1'b0, err_p: 1'b0});
        tick();
        held = 0;
        for (int i = 0; i < 100; i++) begin
            exc_code      = (i % 2 == 1) ? ILLEGAL_INST : NO_ERROR;
            exc_target_pc = PC_W'($urandom);
            tick();
            if (halt && halt_code == HALTED_ON_WFI && dispatch_stall && busy &&
                !rewind_go && !fetch_flush && !store_flush)
                held++;
        end
        check("t5_halt_held_cycles", 64'(held), 64'd100);
        exc_valid = 1'b0;
        exc_code  = NO_ERROR;
        reset = 1'b0;
        #1;
        check_all_zero("t5_reset");
        tick();
        reset = 1'b1;
        tick();

        // T6: reset during REWIND aborts with no flush
        issue_mispredict(32'h0000_5500, 10, 0, 1'b0, 1'b0);
        void'(exp_q.pop_back());                   // aborted: no event expected
        tick();
        exc_valid = 1'b0;
        tick(); rewind_num = 2'd1; phase("t6_rw0", 1'b1, 1'b1, 1'b1);
        tick(); phase("t6_rw1", 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        rewind_num = 2'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // T7: fresh mispredict after reset, 3 younger entries in one cycle
        issue_mispredict(32'h0000_6600, 4, 3, 1'b0, 1'b0);
        tick();
        exc_valid = 1'b0;
        tick(); rewind_num = 2'd3; phase("t7_rw", 1'b1, 1'b1, 1'b1);
        tick(); rewind_num = 2'd0; phase("t7_flush", 1'b0, 1'b1, 1'b1);
        tick(); phase("t7_resume", 1'b0, 1'b1, 1'b1);
        tick(); phase("t7_idle", 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
